inc16_multicycle: RTL and testbench

Multi-cycle 16-bit incrementer for the ALU arithmetic group. It is the counterpart of the registered 16-bit decrementer.
- Computes inp + 1 with a DIGIT-bit ripple slice per clock, under a start/busy/done handshake.
- Produces the result plus carry/overflow/zero/negative flags for the control unit.
- Trades latency for a narrow adder, so the control FSM can sequence it like other multi-cycle ALU ops.

---
 rtl/inc16_multicycle.sv | 174 +++++++++++++++++
 tb/tb_inc16_multicycle.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/inc16_multicycle.sv
`default_nettype none
// ============================================================================
//  Module      : inc16_multicycle
//  Description : Multi-cycle incrementer for the ALU arithmetic group.
//                Computes inp + 1 one DIGIT-bit ripple slice per clock under
//                a start/busy/done handshake. It returns the result together
//                with carry, overflow, zero and negative flags.
//
//  Ports       : clk      - clock, rising edge
//                rst      - asynchronous, active-low reset
//                start    - request, sampled only while idle
//                inp      - operand, captured on the accepting edge
//                busy     - high while a calculation is in progress
//                done     - one-cycle pulse when out/flags are updated
//                out      - result inp+1, held until the next completion
//                carry    - carry out of the MSB
//                overflow - signed overflow (positive operand -> negative)
//                zero     - out == 0
//                neg      - out MSB
//
//  Options     : INC16_SATURATE_EN - when defined, an all-ones operand
//                saturates to all ones (carry=1, neg=1, zero=0) instead
//                of wrapping to zero.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module inc16_multicycle #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] inp,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             neg
);

    localparam int c_NDIG = WIDTH / DIGIT;
    localparam int c_IDXW = (c_NDIG > 1) ? $clog2(c_NDIG) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [WIDTH-1:0]    r_op;
    logic [WIDTH-1:0]    r_res;
    logic [c_IDXW-1:0]   r_idx;
    logic                r_c;

    logic                r_done;
    logic [WIDTH-1:0]    r_out;
    logic                r_carry;
    logic                r_overflow;
    logic                r_zero;
    logic                r_neg;

    logic [DIGIT:0]      w_sum;
    logic [WIDTH-1:0]    w_res_nxt;
    logic                w_last;
    logic [WIDTH-1:0]    w_fin_out;
    logic                w_fin_carry;
    logic                w_fin_ovf;

    // ------------------------------------------------------------------
    // One ripple slice: current operand digit plus the running carry.
    // ------------------------------------------------------------------
    assign w_sum  = {1'b0, r_op[r_idx*DIGIT +: DIGIT]} + {{DIGIT{1'b0}}, r_c};
    assign w_last = (r_idx == c_IDXW'(c_NDIG - 1));

    always_comb begin
        w_res_nxt                       = r_res;
        w_res_nxt[r_idx*DIGIT +: DIGIT] = w_sum[DIGIT-1:0];
    end

    // Completion values, computed from the slice being written this edge so
    // the final digit lands in out on the same edge it is produced.
    always_comb begin
        w_fin_out   = w_res_nxt;
        w_fin_carry = w_sum[DIGIT];
        w_fin_ovf   = ~r_op[WIDTH-1] & w_res_nxt[WIDTH-1];
`ifdef INC16_SATURATE_EN
        if (&r_op) begin
            w_fin_out   = '1;
            w_fin_carry = 1'b1;
            w_fin_ovf   = 1'b0;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start)  w_state_nxt = S_CALC;
            S_CALC: if (w_last) w_state_nxt = S_IDLE;
            default:            w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op       <= '0;
            r_res      <= '0;
            r_idx      <= '0;
            r_c        <= 1'b0;
            r_done     <= 1'b0;
            r_out      <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
            r_neg      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op  <= inp;
                        r_res <= '0;
                        r_idx <= '0;
                        r_c   <= 1'b1;   // the "+1" enters as carry-in
                    end
                end
                S_CALC: begin
                    r_res <= w_res_nxt;
                    r_c   <= w_sum[DIGIT];
                    r_idx <= r_idx + c_IDXW'(1);
                    if (w_last) begin
                        r_idx      <= '0;
                        r_done     <= 1'b1;
                        r_out      <= w_fin_out;
                        r_carry    <= w_fin_carry;
                        r_overflow <= w_fin_ovf;
                        r_zero     <= (w_fin_out == '0);
                        r_neg      <= w_fin_out[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state == S_CALC);
    assign done     = r_done;
    assign out      = r_out;
    assign carry    = r_carry;
    assign overflow = r_overflow;
    assign zero     = r_zero;
    assign neg      = r_neg;

endmodule
`default_nettype wire

// File: tb/tb_inc16_multicycle.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inc16_multicycle
//  Description : Self-checking bench for inc16_multicycle. Directed cases
//                plus randomized operands compared against an arithmetic
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inc16_multicycle;

    localparam int c_W   = 16;
    localparam int c_LAT = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [c_W-1:0] inp;
    logic           busy;
    logic           done;
    logic [c_W-1:0] out;
    logic           carry;
    logic           overflow;
    logic           zero;
    logic           neg;

    int n_total;
    int n_bad;

    inc16_multicycle #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .inp      (inp),
        .busy     (busy),
        .done     (done),
        .out      (out),
        .carry    (carry),
        .overflow (overflow),
        .zero     (zero),
        .neg      (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: arithmetic increment with flags, {out, carry, ovf, zero, neg}
    function automatic logic [c_W+3:0] model(input logic [c_W-1:0] a);
        int unsigned    s;
        logic [c_W-1:0] r;
        logic           c;
        s = int'(a) + 1;
        r = s[c_W-1:0];
        c = (s >= 32'h1_0000);
`ifdef INC16_SATURATE_EN
        if (a == 16'hFFFF) begin
            r = 16'hFFFF;
            c = 1'b1;
        end
`endif
        return {r, c, (a == 16'h7FFF) && (r == 16'h8000), (r == 0), r[c_W-1]};
    endfunction

    task automatic chk_result(input string tag, input logic [c_W-1:0] a);
        logic [c_W+3:0] e;
        e = model(a);
        chk({tag, ".out"},  out,      e[c_W+3:4]);
        chk({tag, ".cy"},   carry,    e[3]);
        chk({tag, ".ov"},   overflow, e[2]);
        chk({tag, ".zero"}, zero,     e[1]);
        chk({tag, ".neg"},  neg,      e[0]);
    endtask

    // Called at a negedge right after the accepting edge. Returns number of
    // edges until done observed (99 when the budget expires).
    task automatic wait_done(input string tag, output int lat);
        lat = 99;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            chk({tag, ".busy"}, busy, 1'b1);
        end
        chk({tag, ".lat"}, lat, c_LAT);
        chk({tag, ".idle"}, busy, 1'b0);
    endtask

    // Full operation from idle: drive at negedge, accept on next posedge.
    task automatic run_op(input string tag, input logic [c_W-1:0] a, input bit noise);
        int lat;
        start = 1'b1;
        inp   = a;
        @(posedge clk); @(negedge clk);
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        inp   = noise ? 16'($urandom) : a;
        wait_done(tag, lat);
        start = 1'b0;
        chk_result(tag, a);
        @(posedge clk); @(negedge clk);
        chk({tag, ".dpulse"}, done, 1'b0);
    endtask

    initial begin
        int lat;
        logic [c_W-1:0] v;
        n_total = 0;
        n_bad   = 0;
        rst   = 1'b0;
        start = 1'b0;
        inp   = '0;
        #15 rst = 1'b1;

        // 1: reset state and basic op
        @(negedge clk);
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.out",  out,  16'h0);
        chk("rst.flags", {carry, overflow, zero, neg}, 4'b0);
        run_op("t1", 16'h000B, 1'b0);

        // 2/3: boundary operands
        run_op("ffff", 16'hFFFF, 1'b0);
        run_op("7fff", 16'h7FFF, 1'b0);
        run_op("00ff", 16'h00FF, 1'b0);

        // 4: start/inp noise during CALC, then start in the done cycle
        start = 1'b1; inp = 16'h1234;
        @(posedge clk); @(negedge clk);
        start = 1'b0; inp = 16'h9999;
        @(posedge clk); @(negedge clk);
        start = 1'b1; inp = 16'h5555;
        @(posedge clk); @(negedge clk);
        start = 1'b0; inp = 16'hAAAA;
        lat = 99;
        for (int k = 3; k <= 12; k++) begin
            @(posedge clk); @(negedge clk);
            if (done) begin lat = k; break; end
        end
        chk("t4.lat", lat, c_LAT);
        chk_result("t4", 16'h1234);
        start = 1'b1; inp = 16'h0000;         // accepted in the done cycle
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        chk("t4.single", done, 1'b0);
        wait_done("t4b", lat);               // 1 accept edge + 4 = 5 cycles
        chk_result("t4b", 16'h0000);

        // start held high: one op every 5 cycles
        for (int n = 0; n < 4; n++) begin
            v = 16'($urandom);
            start = 1'b1; inp = v;
            @(posedge clk); @(negedge clk);
            inp = 16'($urandom);
            wait_done("hold", lat);
            chk_result("hold", v);
        end
        start = 1'b0;
        @(posedge clk); @(negedge clk);

        // 5: reset mid-operation
        start = 1'b1; inp = 16'h0FFF;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5.busy", busy, 1'b0);
        chk("t5.out",  out,  16'h0);
        chk("t5.flags", {carry, overflow, zero, neg}, 4'b0);
        lat = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done) lat++;
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) lat++;
        end
        chk("t5.nodone", lat, 0);
        run_op("t5b", 16'h0FFF, 1'b0);

        // Randomized operands with handshake noise
        for (int n = 0; n < 30; n++) begin
            v = (n % 5 == 0) ? 16'hFFF0 | 16'($urandom_range(0, 15)) : 16'($urandom);
            run_op("rnd", v, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
